// File: rtl/rr_burst_sched_pkg.sv
// Shared types and constants for the weighted round-robin burst scheduler.
package rr_sched_pkg;

   localparam int N     = 4;
   localparam int WGT_W = 4;
   localparam int TO_W  = 8;
   localparam int ID_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // One-hot grant vector for a requester index.
   function automatic logic [N-1:0] onehot4(input logic [ID_W-1:0] id);
      logic [N-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_burst_sched_if.sv
// Requester-side bundle of the scheduler: request/last strobes, per-grant
// configuration, and the registered grant outputs that drive the resource mux.
interface rr_burst_sched_if;
   import rr_sched_pkg::*;

   logic [N-1:0]       req;
   logic [N-1:0]       last;
   logic [N*WGT_W-1:0] weight;
   logic [TO_W-1:0]    timeout;
   logic [N-1:0]       gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               busy;
   logic               to_evt;

   modport master (
      output req, last, weight, timeout,
      input  gnt, gnt_id, busy, to_evt
   );

   modport slave (
      input  req, last, weight, timeout,
      output gnt, gnt_id, busy, to_evt
   );

endinterface

// File: rtl/rr_burst_sched_pick4.sv
// Round-robin picker: first set request bit searching upward from ptr, mod 4.
module rr_pick4
   import rr_sched_pkg::*;
(
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] sel,
   output logic            any
);

   logic [ID_W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      sel = ptr;
      any = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr + ID_W'(k);
         if (req[idx]) begin
            sel = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_burst_sched.sv
// Weighted round-robin scheduler with grant hold, watchdog and a dead cycle
// between grants so the resource mux never switches between two live owners.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick next requester from ptr on any request
// GRANT | owner gnt_id holds the resource; count last strobes / watchdog
// GAP   | one dead cycle after release, gnt = 0, then back to IDLE
module rr_burst_sched
   import rr_sched_pkg::*;
(
   input logic         clk,
   input logic         rst,
   rr_burst_sched_if.slave bus
);

   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [WGT_W-1:0] credit_q, credit_d;
   logic [TO_W-1:0] timer_q, timer_d;
   logic [TO_W-1:0] to_lat_q, to_lat_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic            busy_q, busy_d;
   logic            to_evt_q, to_evt_d;

   logic [ID_W-1:0]  pick_sel;
   logic             pick_any;
   logic [WGT_W-1:0] wgt_arr [N];
   logic [WGT_W-1:0] wgt_pick;
   logic [WGT_W-1:0] credit_dec;
   logic             req_g;
   logic             last_g;
   logic             wd_on;
   logic             release_now;

   rr_pick4 u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .sel (pick_sel),
      .any (pick_any)
   );

   for (genvar i = 0; i < N; i++) begin : g_wgt
      assign wgt_arr[i] = bus.weight[i*WGT_W +: WGT_W];
   end

   assign wgt_pick   = wgt_arr[pick_sel];
   assign credit_dec = credit_q - WGT_W'(1);
   assign req_g      = bus.req[gnt_id_q];
   assign last_g     = bus.last[gnt_id_q];
   assign wd_on      = (to_lat_q != '0);

   // State and datapath registers; everything the requesters see is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         credit_q <= '0;
         timer_q  <= '0;
         to_lat_q <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         to_evt_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         timer_q  <= timer_d;
         to_lat_q <= to_lat_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         to_evt_q <= to_evt_d;
      end
   end

   // Next-state logic: grant from IDLE, hold/release rules in GRANT, dead cycle in GAP.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      credit_d    = credit_q;
      timer_d     = timer_q;
      to_lat_d    = to_lat_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      busy_d      = busy_q;
      to_evt_d    = 1'b0;
      release_now = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d  = GRANT;
               gnt_d    = onehot4(pick_sel);
               gnt_id_d = pick_sel;
               busy_d   = 1'b1;
               credit_d = (wgt_pick == '0) ? WGT_W'(1) : wgt_pick;
               timer_d  = bus.timeout;
               to_lat_d = bus.timeout;
            end
         end
         GRANT: begin
            // last beats a simultaneous watchdog expiry, so no to_evt then.
            if (!req_g) begin
               release_now = 1'b1;
            end else if (last_g) begin
               credit_d = credit_dec;
               if (credit_dec == '0) begin
                  release_now = 1'b1;
               end else begin
                  timer_d = to_lat_q;
               end
            end else if (wd_on && timer_q == TO_W'(1)) begin
               release_now = 1'b1;
               to_evt_d    = 1'b1;
            end else if (wd_on) begin
               timer_d = timer_q - TO_W'(1);
            end

            if (release_now) begin
               state_d = GAP;
               ptr_d   = gnt_id_q + ID_W'(1);
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt_id = gnt_id_q;
   assign bus.busy   = busy_q;
   assign bus.to_evt = to_evt_q;

endmodule
